// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and halt decode for the fetch stage
package fetch_pkg;

    localparam logic [15:0] NOP_INST         = 16'h1000;
    localparam logic [3:0]  HALT_OPCODE_DEF  = 4'hF;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] inst, input logic [3:0] opcode);
        return inst[15:12] == opcode;
    endfunction

endpackage

// File: rtl/pc_incr.sv
// rtl/pc_incr.sv - 16-bit PC + 2 adder, wraps modulo 2^16
module pc_incr (
    input  logic [15:0] pc,
    output logic [15:0] pc_plus_two
);

    assign pc_plus_two = pc + 16'd2;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem handshake, IF/ID write/flush control
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] instruction,
    output logic [15:0] PC_plus_two,
    output logic        IF_write,
    output logic        IF_flush,
    output logic        halted
);

    fetch_state_t state, state_next;
    logic [15:0]  pc, pc_next, pc_plus;
    logic [15:0]  hold_inst, hold_next;
    logic [15:0]  pend_target, pend_next;

    pc_incr u_pc_incr (
        .pc          (pc),
        .pc_plus_two (pc_plus)
    );

    assign imem_addr   = pc;
    assign PC_plus_two = pc_plus;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_inst   <= NOP_INST;
            pend_target <= RESET_PC;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            hold_inst   <= hold_next;
            pend_target <= pend_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        hold_next   = hold_inst;
        pend_next   = pend_target;
        imem_req    = 1'b0;
        IF_write    = 1'b0;
        IF_flush    = 1'b0;
        halted      = 1'b0;
        instruction = NOP_INST;

        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready && !stall) begin
                    IF_write    = 1'b1;
                    instruction = imem_data;
                    if (is_halt(imem_data, HALT_OPCODE)) state_next = HALTED;
                    else                                 pc_next    = pc_plus;
                end else if (imem_ready) begin
                    hold_next  = imem_data;
                    state_next = HOLD;
                end else if (!stall) begin
                    IF_write = 1'b1;
                    IF_flush = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    IF_write    = 1'b1;
                    instruction = hold_inst;
                    if (is_halt(hold_inst, HALT_OPCODE)) begin
                        state_next = HALTED;
                    end else begin
                        pc_next    = pc_plus;
                        state_next = FETCH;
                    end
                end
            end
            DRAIN: begin
                // Outstanding request at the old address must complete before redirecting.
                imem_req = 1'b1;
                IF_write = 1'b1;
                IF_flush = 1'b1;
                if (imem_ready) begin
                    pc_next    = pend_target;
                    state_next = FETCH;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (!stall) begin
                    IF_write = 1'b1;
                    IF_flush = 1'b1;
                end
            end
            default: state_next = FETCH;
        endcase

        if (branch_taken) begin
            IF_write    = 1'b1;
            IF_flush    = 1'b1;
            instruction = NOP_INST;
            if (imem_req && !imem_ready) begin
                pc_next    = pc;
                pend_next  = branch_target;
                state_next = DRAIN;
            end else begin
                pc_next    = branch_target;
                state_next = FETCH;
            end
        end

        if (!rst) begin
            imem_req    = 1'b0;
            IF_write    = 1'b0;
            IF_flush    = 1'b0;
            halted      = 1'b0;
            instruction = NOP_INST;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: owns the program counter, runs the request/ready handshake with instruction memory, and drives the instruction and PC+2 into the IF/ID pipeline register together with that register's write and flush controls. It is the stage directly upstream of IF/ID. It absorbs memory wait states, hazard-unit stalls, taken-branch redirects from EX, and the halt instruction.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, opcode in instruction[15:12] that halts fetch.

Ports:
- clk, input, 1, clock. All state updates on its rising edge.
- rst, input, 1, reset. One clock; reset is asynchronous and active-low.
- stall, input, 1, hazard unit requests that IF/ID hold its contents.
- branch_taken, input, 1, redirect from EX; single-cycle pulse.
- branch_target, input, 16, redirect PC, valid when branch_taken=1.
- imem_req, output, 1, instruction-memory request.
- imem_addr, output, 16, fetch address. Equals PC.
- imem_ready, input, 1, memory returns imem_data this cycle. May be asserted in the same cycle as imem_req.
- imem_data, input, 16, fetched instruction.
- instruction, output, 16, to IF/ID instruction input.
- PC_plus_two, output, 16, to IF/ID PC input. Equals PC+2 of the instruction being delivered.
- IF_write, output, 1, IF/ID write enable.
- IF_flush, output, 1, IF/ID flush; converts the written instruction to NOP 16'h1000.
- halted, output, 1, fetch is parked on a halt.

## Operation
- State registers:
  - state, one of FETCH, HOLD, DRAIN, HALTED.
  - PC, 16 bits.
  - hold_inst, 16 bits.
  - pend_target, 16 bits.
- Reset:
  - PC=RESET_PC, state=FETCH.
  - While rst=0: imem_req=0, IF_write=0, IF_flush=0, halted=0, instruction=16'h1000, PC_plus_two=RESET_PC+2.
- Handshake rule: once imem_req rises, imem_addr must stay stable until the cycle in which imem_ready=1.
- FETCH state:
  - imem_req=1.
  - ready=1, stall=0: deliver imem_data (IF_write=1, IF_flush=0), PC<=PC+2. If imem_data[15:12]==HALT_OPCODE, deliver it, hold PC, go to HALTED.
  - ready=1, stall=1: hold_inst<=imem_data, IF_write=0, PC held, go to HOLD.
  - ready=0, stall=0: bubble (IF_write=1, IF_flush=1), PC held.
  - ready=0, stall=1: IF_write=0, keep requesting.
- HOLD state:
  - imem_req=0.
  - stall=1: IF_write=0.
  - stall=0: deliver hold_inst, PC<=PC+2, go to FETCH. The halt check applies to hold_inst exactly as in FETCH.
- DRAIN state:
  - imem_req=1 at the old address.
  - Emit bubbles each cycle.
  - On ready=1: discard the data, PC<=pend_target, go to FETCH.
- HALTED state:
  - imem_req=0, halted=1.
  - Bubbles when stall=0; IF_write=0 when stall=1.
- branch_taken=1 has priority over stall, ready and halt in every state. It forces IF_write=1 and IF_flush=1 that cycle.
  - FETCH with ready=0: pend_target<=branch_target, go to DRAIN.
  - DRAIN with ready=0: pend_target is overwritten (last redirect wins).
  - Otherwise: PC<=branch_target, state<=FETCH, hold_inst discarded, halted cleared next cycle.
- Arithmetic: PC+2 is modulo 2^16; PC 16'hFFFE wraps to 16'h0000.

## Timing
- Zero-wait memory: one instruction delivered per cycle. The halt check and delivery are combinational from imem_data.
- Fetch latency is 1 + N cycles for N wait states, with N bubbles emitted.
- Redirect: the first instruction from branch_target is delivered no earlier than the cycle after branch_taken. In DRAIN it is delivered no earlier than one cycle after the outstanding ready.
- Reset asserted mid-handshake: imem_req drops asynchronously. Memory must tolerate an abandoned request.
- All outputs other than registered state are combinational from state, PC, hold_inst and the inputs.

## Structure
- Shared package (fetch_pkg): NOP constant 16'h1000, HALT_OPCODE default, and state encoding (2 bits).
- PC, hold_inst and pend_target are local async-active-low registers.
- One natural sub-module is pc_incr: a 16-bit +2 adder, reused for PC_plus_two and the next PC.

## Test plan
- Reset release with RESET_PC=0 and zero-wait memory returning 16'hA123, 16'hB456 -> IF_write=1 each cycle, delivered PC_plus_two=2 then 4, IF_flush=0.
- imem_ready held low 3 cycles at PC=16'h0010 -> 3 bubbles (IF_flush=1), imem_addr constant 16'h0010. The 4th cycle delivers the instruction with PC_plus_two=16'h0012.
- stall=1 for 2 cycles while ready=1 returns 16'h2345 -> IF_write=0 for 2 cycles, imem_req=0 in HOLD. 16'h2345 is delivered in the cycle stall drops.
- branch_taken with target 16'h0100 during a wait state at PC 16'h0020 -> DRAIN. Data returned at 16'h0020 is discarded, the next imem_addr is 16'h0100, and every cycle in between is a bubble.
- Fetch 16'hF000 -> delivered once, halted=1 next cycle, imem_req=0, bubbles thereafter. A later branch_taken to 16'h0040 restarts fetch at 16'h0040 with halted=0.
- Assert rst low mid-wait at PC 16'h0030 -> imem_req=0 immediately. After release, the first imem_addr is RESET_PC.
